fp_add_dispatch: RTL and testbench

FP_ADD_DISPATCH -- requirements
Module: fp_add_dispatch

---
 rtl/fp_add_pkg.sv | 11 +
 rtl/fp_add_dispatch_tag_fifo.sv | 45 ++++
 rtl/fp_add_dispatch.sv | 144 ++++++++++++++
 tb/tb_fp_add_dispatch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared operand width, default order-FIFO depth and path tag encoding
package fp_add_pkg;
  localparam int DEF_W     = 37;
  localparam int DEF_DEPTH = 4;
  typedef enum logic [1:0] {
    PATH0     = 2'd0,
    PATH1     = 2'd1,
    PATH2     = 2'd2,
    PATH_NONE = 2'd3
  } path_e;
endpackage

// File: rtl/fp_add_dispatch_tag_fifo.sv
// tag_fifo: order-tag FIFO recording which path each accepted pair went to
//   clk, rst_n      : clock, synchronous active-low reset
//   push, din       : write a tag (ignored while full, even if popping)
//   pop             : drop the head tag (ignored while empty)
//   full, empty     : occupancy flags
//   head            : oldest tag
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [TW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign head   = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/fp_add_dispatch.sv
// fp_add_dispatch: dispatches operand pairs to three adder paths and returns results in acceptance order
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready           : operand pair handshake (in_na, in_nb, in_sel)
//   p_na, p_nb, pK_valid/ready  : shared operand bus and per-path dispatch handshake
//   rK_valid/ready, rK_data     : per-path result return
//   out_valid/ready, out_data   : in-order result stream; out_err marks unsupported selects
module fp_add_dispatch
  import fp_add_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_na,
  input  logic [W-1:0] in_nb,
  input  logic [1:0]   in_sel,
  output logic [W-1:0] p_na,
  output logic [W-1:0] p_nb,
  output logic         p0_valid,
  output logic         p1_valid,
  output logic         p2_valid,
  input  logic         p0_ready,
  input  logic         p1_ready,
  input  logic         p2_ready,
  input  logic         r0_valid,
  input  logic         r1_valid,
  input  logic         r2_valid,
  input  logic [W-1:0] r0_data,
  input  logic [W-1:0] r1_data,
  input  logic [W-1:0] r2_data,
  output logic         r0_ready,
  output logic         r1_ready,
  output logic         r2_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);
  localparam int CW = $clog2(DEPTH + 1);
  logic         r_disp_v;
  logic [W-1:0] r_na, r_nb;
  logic [1:0]   r_sel;
  logic [2:0]   r_hold_v;
  logic [W-1:0] r_hold_d [3];
  logic [CW-1:0] r_pend [3];
  logic         r_quiet;
  logic         w_full, w_empty, w_dv, w_disp_fire, w_out_fire;
  logic [1:0]   w_head;
  logic [2:0]   w_r_valid, w_r_ready;
  logic [3:0]   w_sel_rdy, w_hv;
  logic [W-1:0] w_r_data [3];
  logic [W-1:0] w_od [4];
  // select 3 needs no path, so it always counts as ready
  assign w_sel_rdy   = {1'b1, p2_ready, p1_ready, p0_ready};
  assign w_disp_fire = r_disp_v && !w_full && w_sel_rdy[r_sel];
  assign in_ready    = !r_disp_v || w_disp_fire;
  assign w_dv        = r_disp_v && !w_full;
  assign p0_valid    = w_dv && r_sel == PATH0;
  assign p1_valid    = w_dv && r_sel == PATH1;
  assign p2_valid    = w_dv && r_sel == PATH2;
  assign p_na        = r_na;
  assign p_nb        = r_nb;
  assign w_r_valid   = {r2_valid, r1_valid, r0_valid};
  assign w_r_data[0] = r0_data;
  assign w_r_data[1] = r1_data;
  assign w_r_data[2] = r2_data;
  // the unsupported tag is always "ready" with a zero payload
  assign w_hv        = {1'b1, r_hold_v};
  assign w_od[0]     = r_hold_d[0];
  assign w_od[1]     = r_hold_d[1];
  assign w_od[2]     = r_hold_d[2];
  assign w_od[3]     = '0;
  assign out_valid   = !w_empty && w_hv[w_head];
  assign w_out_fire  = out_valid && out_ready;
  assign out_data    = w_od[w_head];
  assign out_err     = !w_empty && w_head == PATH_NONE;
  assign {r2_ready, r1_ready, r0_ready} = w_r_ready;
  always_comb begin
    w_r_ready = '0;
    for (int k = 0; k < 3; k++) w_r_ready[k] = !r_hold_v[k] || (w_out_fire && w_head == 2'(k));
  end
  tag_fifo #(.DEPTH(DEPTH), .TW(2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_disp_fire),
    .pop   (w_out_fire),
    .din   (r_sel),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_v <= 1'b0;
      r_na     <= '0;
      r_nb     <= '0;
      r_sel    <= '0;
    end else if (in_ready) begin
      r_disp_v <= in_valid;
      if (in_valid) begin
        r_na  <= in_na;
        r_nb  <= in_nb;
        r_sel <= in_sel;
      end
    end
  end
  // a hold register freed by the output on this edge may reload on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_v <= '0;
      for (int k = 0; k < 3; k++) r_hold_d[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_r_valid[k] && w_r_ready[k]) begin
          r_hold_v[k] <= 1'b1;
          r_hold_d[k] <= w_r_data[k];
        end else if (w_out_fire && w_head == 2'(k)) begin
          r_hold_v[k] <= 1'b0;
        end
      end
    end
  end
  // per-path count of dispatched pairs whose result has not come back yet;
  // checking is suspended after reset until new work is dispatched, since
  // paths may still be flushing results of discarded pairs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quiet <= 1'b1;
      for (int k = 0; k < 3; k++) r_pend[k] <= '0;
    end else begin
      if (w_disp_fire) r_quiet <= 1'b0;
      for (int k = 0; k < 3; k++)
        r_pend[k] <= r_pend[k] + CW'(w_disp_fire && r_sel == 2'(k))
                     - CW'(w_r_valid[k] && w_r_ready[k] && r_pend[k] != '0);
    end
  end
  always @(posedge clk) begin
    if (rst_n && !r_quiet)
      for (int k = 0; k < 3; k++) assert (!w_r_valid[k] || r_pend[k] != '0);
  end
endmodule

// File: tb/tb_fp_add_dispatch.sv
// tb_fp_add_dispatch: table-driven and scoreboard checks of the in-order dispatcher
module tb_fp_add_dispatch;
  import fp_add_pkg::*;
  localparam int W = DEF_W;
  typedef struct {
    logic [W-1:0] na;
    logic [W-1:0] nb;
    logic [1:0]   sel;
    logic [W-1:0] ed;
    logic         ee;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_na = '0, in_nb = '0;
  logic [1:0] in_sel = '0;
  logic [W-1:0] p_na, p_nb;
  logic p0_valid, p1_valid, p2_valid;
  logic p0_ready = 1'b0, p1_ready = 1'b0, p2_ready = 1'b0;
  logic r0_valid = 1'b0, r1_valid = 1'b0, r2_valid = 1'b0;
  logic [W-1:0] r0_data = '0, r1_data = '0, r2_data = '0;
  logic r0_ready, r1_ready, r2_ready;
  logic out_valid, out_ready = 1'b0, out_err;
  logic [W-1:0] out_data;
  int n_cmp = 0, n_err = 0;
  vec_t tbl [10];
  vec_t stim [$];
  vec_t sb [$];
  logic [W-1:0] q0 [$], q1 [$], q2 [$];
  logic [2:0] prdy = 3'b111, ret_en = 3'b111;
  logic ordy = 1'b1, in_en = 1'b1;

  fp_add_dispatch #(.DEPTH(DEF_DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_na(in_na), .in_nb(in_nb), .in_sel(in_sel),
    .p_na(p_na), .p_nb(p_nb),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p2_valid(p2_valid),
    .p0_ready(p0_ready), .p1_ready(p1_ready), .p2_ready(p2_ready),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
    .r0_data(r0_data), .r1_data(r1_data), .r2_data(r2_data),
    .r0_ready(r0_ready), .r1_ready(r1_ready), .r2_ready(r2_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] na, input logic [W-1:0] nb, input logic [1:0] sel,
                              input logic [W-1:0] ed, input logic ee);
    vec_t v;
    v.na = na; v.nb = nb; v.sel = sel; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  // one clock: drive at negedge, sample handshakes 1ns later, step the path/scoreboard models
  task automatic cycle();
    vec_t e;
    @(negedge clk);
    in_valid = rst_n && in_en && stim.size() > 0;
    if (stim.size() > 0) begin
      in_na = stim[0].na; in_nb = stim[0].nb; in_sel = stim[0].sel;
    end
    {p2_ready, p1_ready, p0_ready} = prdy;
    r0_valid = rst_n && ret_en[0] && q0.size() > 0;
    r1_valid = rst_n && ret_en[1] && q1.size() > 0;
    r2_valid = rst_n && ret_en[2] && q2.size() > 0;
    if (q0.size() > 0) r0_data = q0[0];
    if (q1.size() > 0) r1_data = q1[0];
    if (q2.size() > 0) r2_data = q2[0];
    out_ready = ordy;
    #1;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(stim[0]);
        void'(stim.pop_front());
      end
      if (p0_valid && p0_ready) q0.push_back(W'(p_na + p_nb));
      if (p1_valid && p1_ready) q1.push_back(W'(p_na + p_nb + 1));
      if (p2_valid && p2_ready) q2.push_back(W'(p_na + p_nb + 2));
      if (r0_valid && r0_ready) void'(q0.pop_front());
      if (r1_valid && r1_ready) void'(q1.pop_front());
      if (r2_valid && r2_ready) void'(q2.pop_front());
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got data %h err %b expected no output", out_data, out_err);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.ed);
          chk1("out_err", out_err, e.ee);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(input int budget, input bit rnd);
    int c = 0;
    while ((stim.size() > 0 || sb.size() > 0) && c < budget) begin
      if (rnd) begin
        prdy = 3'($urandom); ret_en = 3'($urandom);
        ordy = 1'($urandom); in_en = 1'($urandom);
      end
      cycle();
      c++;
    end
    prdy = 3'b111; ret_en = 3'b111; ordy = 1'b1; in_en = 1'b1;
    n_cmp++;
    if (stim.size() > 0 || sb.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d unsent %0d unreturned expected 0 0", stim.size(), sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; r2_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete(); sb.delete(); q0.delete(); q1.delete(); q2.delete();
    #1;
  endtask

  initial begin
    tbl[0] = '{37'h0_0000_1000, 37'h0_0000_0233, 2'd1, 37'h0_0000_1234, 1'b0};
    tbl[1] = '{37'h0_0000_0010, 37'h0_0000_0020, 2'd0, 37'h0_0000_0030, 1'b0};
    tbl[2] = '{37'h0_0000_0100, 37'h0_0000_0200, 2'd2, 37'h0_0000_0302, 1'b0};
    tbl[3] = '{37'h1F_FFFF_FFFF, 37'h0_0000_0001, 2'd0, 37'h0_0000_0000, 1'b0};
    tbl[4] = '{37'h0_0000_0005, 37'h0_0000_0006, 2'd3, 37'h0_0000_0000, 1'b1};
    tbl[5] = '{37'h1F_FFFF_FFFF, 37'h1F_FFFF_FFFF, 2'd1, 37'h1F_FFFF_FFFF, 1'b0};
    tbl[6] = '{37'h0_0000_0ABC, 37'h0_0000_0000, 2'd2, 37'h0_0000_0ABE, 1'b0};
    tbl[7] = '{37'h0_0000_0000, 37'h0_0000_0000, 2'd3, 37'h0_0000_0000, 1'b1};
    tbl[8] = '{37'h12_3456_789A, 37'h0_0000_0000, 2'd0, 37'h12_3456_789A, 1'b0};
    tbl[9] = '{37'h0_0000_0007, 37'h0_0000_0001, 2'd1, 37'h0_0000_0009, 1'b0};

    do_reset();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_p_valid", W'({p2_valid, p1_valid, p0_valid}), W'(0));
    chk("rst_p_na", p_na, '0);
    chk("rst_p_nb", p_nb, '0);
    chk("rst_r_ready", W'({r2_ready, r1_ready, r0_ready}), W'(7));
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk1("rst_out_err", out_err, 1'b0);

    // single pair on path 1: offered to the path the cycle after acceptance
    stim.push_back(tbl[0]);
    cycle();
    #2;
    chk("single_accepted", W'(sb.size()), W'(1));
    chk1("single_p1_valid", p1_valid, 1'b1);
    chk("single_p_na", p_na, 37'h1000);
    drain(50, 1'b0);

    // paths 0,1,2 back-to-back, results returned 2,1,0
    ret_en = 3'b000;
    stim.push_back(mk(37'h10, 37'h20, 2'd0, 37'h30, 1'b0));
    stim.push_back(mk(37'h40, 37'h50, 2'd1, 37'h91, 1'b0));
    stim.push_back(mk(37'h60, 37'h70, 2'd2, 37'hD2, 1'b0));
    repeat (6) cycle();
    #2;
    chk("ooo_dispatched", W'(q0.size() + q1.size() + q2.size()), W'(3));
    ret_en = 3'b100;
    repeat (2) cycle();
    #2;
    chk1("ooo_stall_after_r2", out_valid, 1'b0);
    ret_en = 3'b110;
    repeat (2) cycle();
    #2;
    chk1("ooo_stall_after_r1", out_valid, 1'b0);
    ret_en = 3'b111;
    drain(50, 1'b0);

    // full tag FIFO holds the fifth pair in the dispatch register
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) stim.push_back(mk(W'(i + 1), W'(2), 2'd0, W'(i + 3), 1'b0));
    repeat (7) cycle();
    #2;
    chk("full_accepted", W'(sb.size()), W'(5));
    chk1("full_p0_valid", p0_valid, 1'b0);
    chk1("full_in_ready", in_ready, 1'b0);
    chk1("full_out_valid", out_valid, 1'b1);
    ordy = 1'b1;
    cycle();
    ordy = 1'b0;
    #2;
    chk1("full_resume_p0_valid", p0_valid, 1'b1);
    ordy = 1'b1;
    drain(100, 1'b0);

    // path 2 not ready: one pair buffered, operands held steady
    prdy = 3'b011;
    for (int i = 0; i < 3; i++) stim.push_back(mk(W'(37'h2A0 + i), W'(1), 2'd2, W'(37'h2A3 + i), 1'b0));
    repeat (2) cycle();
    #2;
    chk1("stall_in_ready", in_ready, 1'b0);
    chk1("stall_p2_valid", p2_valid, 1'b1);
    chk("stall_p_na", p_na, 37'h2A0);
    repeat (2) cycle();
    #2;
    chk("stall_p_na_stable", p_na, 37'h2A0);
    chk("stall_accepted", W'(sb.size()), W'(1));
    prdy = 3'b111;
    drain(100, 1'b0);

    // reset with three tags outstanding
    ret_en = 3'b000;
    stim.push_back(mk(37'h11, 37'h1, 2'd0, 37'h12, 1'b0));
    stim.push_back(mk(37'h22, 37'h1, 2'd1, 37'h24, 1'b0));
    stim.push_back(mk(37'h33, 37'h1, 2'd0, 37'h34, 1'b0));
    repeat (6) cycle();
    #2;
    chk("pre_rst_outstanding", W'(sb.size()), W'(3));
    do_reset();
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_p_valid", W'({p2_valid, p1_valid, p0_valid}), W'(0));
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 37'h5A;
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    chk1("late_r0_no_output", out_valid, 1'b0);
    ret_en = 3'b111;
    do_reset();

    // full table with random back-pressure and out-of-order returns
    for (int i = 0; i < 10; i++) stim.push_back(tbl[i]);
    for (int i = 0; i < 10; i++) stim.push_back(tbl[9 - i]);
    drain(3000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
